click_report_sequencer: RTL
===========================

Name: click_report_sequencer

Overview:
- Sits between the dwell/spike click-pulse generator and the HID report transmitter.
- Queues one-cycle left/right click pulses and accumulates signed dx/dy motion.
- Sequences each click into a press report, a timed hold, a release report and an inter-click gap.
- Emits all reports, click and motion-only, over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, click-event queue entries; power of two, ≥2.
- HOLD_CYCLES, 8, cycles between press-report handshake and release-report assertion.
- GAP_CYCLES, 4, cycles after release-report handshake before the next event is eligible.
- REPORT_PERIOD, 16, minimum cycles between motion-only reports.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- enable  in  1  1 = accept clicks and motion; 0 = ignore new inputs, finish any sequence in progress.
- left_click_pulse  in  1  one-cycle left click event.
- right_click_pulse  in  1  one-cycle right click event.
- dx  in  8  signed per-cycle X motion.
- dy  in  8  signed per-cycle Y motion.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  transmitter accepts report; handshake = rpt_valid & rpt_ready.
- rpt_buttons  out  2  bit0 = left, bit1 = right.
- rpt_dx  out  8  signed X motion carried by the report.
- rpt_dy  out  8  signed Y motion carried by the report.
- fifo_full  out  1  event queue full.
- drop_cnt  out  8  dropped click events; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears every register, with these results:
  - All outputs read 0.
  - FIFO is empty.
  - Accumulators and counters are 0.
  - FSM is in IDLE.
  - A reset mid-sequence abandons it; no release report is emitted.
- Enqueue (enable=1):
  - Left pulse alone pushes code 01; right pulse alone pushes 10.
  - Both pulses in the same cycle push a single entry 11.
  - Write is registered: the entry becomes visible one cycle after the pulse.
  - Push while full: entry discarded, drop_cnt += 1 (saturating).
  - A pop and a push in the same cycle while full both succeed; nothing is dropped.
  - fifo_full is a registered count==FIFO_DEPTH.
- Motion accumulators acc_x / acc_y (signed 8-bit):
  - Each cycle with enable=1, acc += dx/dy, saturating to [-128, 127].
  - Wrap-around is forbidden.
  - When a report is launched (rpt_valid rises), acc is copied to rpt_dx/rpt_dy.
  - In that same cycle, acc is loaded with that cycle's dx/dy (0 if enable=0).
- Payload stability: while rpt_valid=1 and rpt_ready=0, rpt_buttons, rpt_dx and rpt_dy hold constant; motion keeps accumulating in acc.
- rpt_valid deasserts the cycle after the handshake unless the FSM launches again.
- period_cnt:
  - Counts cycles since the last handshake, saturating at REPORT_PERIOD.
  - Cleared on every handshake.
- FSM:
  - IDLE:
    - If the FIFO is non-empty: pop the head, launch a report with rpt_buttons = code → PRESS_WAIT.
    - Else if acc≠0 and period_cnt==REPORT_PERIOD: launch a report with rpt_buttons=00 → MOTION_WAIT.
    - Click has priority over motion.
  - PRESS_WAIT: on handshake, load hold_cnt=0 → HOLD.
  - HOLD:
    - hold_cnt increments each cycle.
    - At hold_cnt==HOLD_CYCLES-1, launch a release report with rpt_buttons=00 and motion = acc → RELEASE_WAIT.
    - No motion-only reports are launched during HOLD.
  - RELEASE_WAIT: on handshake, gap_cnt=0 → GAP.
  - GAP: at gap_cnt==GAP_CYCLES-1 → IDLE.
  - MOTION_WAIT: on handshake → IDLE.
- Latency: with the FIFO empty, the FSM in IDLE and enable=1, a click pulse at cycle T gives rpt_valid=1 at T+2.
- With rpt_ready held at 1:
  - The release report rises HOLD_CYCLES+1 cycles after the press handshake.
  - The next click report rises no earlier than GAP_CYCLES+1 cycles after the release handshake.
- enable=0:
  - Pulses are not queued and do not increment drop_cnt.
  - Motion is not accumulated.
  - Queued events still drain; in-flight handshakes complete.

Test Plan:
- Reset, single left pulse at T, rpt_ready=1, dx=dy=0:
  - Required: rpt_valid at T+2 with buttons=01 and dx=dy=0.
  - Then buttons=00 exactly HOLD_CYCLES+1 cycles after the press handshake.
- Left and right pulses in the same cycle: required is one press report with buttons=11, then one release report with 00; no second press.
- Six left pulses on consecutive cycles, rpt_ready=0 throughout:
  - Required: FIFO fills; the first event is popped at launch, so after the six pulses fifo_full=1 and drop_cnt=1.
  - Raise rpt_ready: exactly five press/release pairs are emitted, gaps ≥ GAP_CYCLES.
- dx=+100 for 3 cycles, dy=-100 for 3 cycles, no clicks: required is a motion report with dx=127, dy=-128 (saturated), buttons=00.
- rpt_ready=0 for 10 cycles while a report is valid and dx=+1 each cycle:
  - Required: payload unchanged throughout the stall.
  - The next report carries the accumulated motion, ≥10.
- Assert rst_n=0 during HOLD:
  - Required: all outputs 0 next cycle, FIFO empty, no release report after reset.

Source files
------------

// File: rtl/click_report_sequencer.sv
// Click report sequencer.
// Queues left/right click pulses, accumulates signed motion, and turns every click into a
// press report, a timed hold, a release report and an inter-click gap. Motion-only reports
// are sent from idle when motion is pending and the report period has elapsed.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   enable                       accept new clicks and motion when 1
//   left_click_pulse             one-cycle left click event
//   right_click_pulse            one-cycle right click event
//   dx, dy                       signed per-cycle motion
//   rpt_valid, rpt_ready         report handshake
//   rpt_buttons, rpt_dx, rpt_dy  report payload (buttons bit0 = left, bit1 = right)
//   fifo_full                    click queue full
//   drop_cnt                     saturating count of dropped click events
module click_report_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned REPORT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       left_click_pulse,
  input  logic       right_click_pulse,
  input  logic [7:0] dx,
  input  logic [7:0] dy,
  output logic       rpt_valid,
  input  logic       rpt_ready,
  output logic [1:0] rpt_buttons,
  output logic [7:0] rpt_dx,
  output logic [7:0] rpt_dy,
  output logic       fifo_full,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned PW = $clog2(REPORT_PERIOD + 1);

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StPressWait   = 3'd1;
  localparam logic [2:0] StHold        = 3'd2;
  localparam logic [2:0] StReleaseWait = 3'd3;
  localparam logic [2:0] StGap         = 3'd4;
  localparam logic [2:0] StMotionWait  = 3'd5;

  // Signed 8-bit add clamped to [-128, 127].
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) begin
      return s[8] ? 8'h80 : 8'h7F;
    end
    return s[7:0];
  endfunction

  logic [1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic [7:0]    drop_q;

  logic [7:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [PW-1:0] period_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    state_q, state_d;

  logic          valid_q;
  logic [1:0]    buttons_q;
  logic [7:0]    rdx_q, rdy_q;

  logic          push_req, push, pop, drop, is_full, hs, launch;
  logic [1:0]    push_code, launch_buttons;

  assign hs        = valid_q & rpt_ready;
  assign push_code = {right_click_pulse, left_click_pulse};
  assign push_req  = enable & (left_click_pulse | right_click_pulse);
  assign is_full   = (count_q == CW'(FIFO_DEPTH));
  // Idle always launches when the queue is non-empty, so a pop is exactly that condition.
  assign pop       = (state_q == StIdle) && (count_q != '0);
  // A pop frees the slot in the same cycle, so a full queue can still accept a push.
  assign push      = push_req & (~is_full | pop);
  assign drop      = push_req & is_full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    gap_d          = gap_q;
    launch         = 1'b0;
    launch_buttons = 2'b00;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          launch         = 1'b1;
          launch_buttons = fifo_mem_q[rd_ptr_q];
          state_d        = StPressWait;
        end else if ((acc_x_q != 8'h00 || acc_y_q != 8'h00) &&
                     period_q == PW'(REPORT_PERIOD)) begin
          launch  = 1'b1;
          state_d = StMotionWait;
        end
      end
      StPressWait: begin
        if (hs) begin
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          launch  = 1'b1;
          state_d = StReleaseWait;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StReleaseWait: begin
        if (hs) begin
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StMotionWait: begin
        if (hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // On launch the accumulator restarts from this cycle's motion so nothing is lost or counted
  // twice; otherwise it keeps saturating-accumulating, including while a report is stalled.
  always_comb begin
    if (launch) begin
      acc_x_d = enable ? dx : 8'h00;
      acc_y_d = enable ? dy : 8'h00;
    end else if (enable) begin
      acc_x_d = sat_add(acc_x_q, dx);
      acc_y_d = sat_add(acc_y_q, dy);
    end else begin
      acc_x_d = acc_x_q;
      acc_y_d = acc_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 2'b00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      drop_q    <= 8'h00;
      acc_x_q   <= 8'h00;
      acc_y_q   <= 8'h00;
      period_q  <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      buttons_q <= 2'b00;
      rdx_q     <= 8'h00;
      rdy_q     <= 8'h00;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      if (drop && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      if (hs) begin
        period_q <= '0;
      end else if (period_q != PW'(REPORT_PERIOD)) begin
        period_q <= period_q + 1'b1;
      end
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      state_q <= state_d;
      // Launches only happen from idle or hold, where no report is outstanding.
      if (launch) begin
        valid_q   <= 1'b1;
        buttons_q <= launch_buttons;
        rdx_q     <= acc_x_q;
        rdy_q     <= acc_y_q;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rpt_valid   = valid_q;
  assign rpt_buttons = buttons_q;
  assign rpt_dx      = rdx_q;
  assign rpt_dy      = rdy_q;
  assign fifo_full   = full_q;
  assign drop_cnt    = drop_q;

endmodule
